// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}, dp kept off
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan scheduler with blanking, leading-zero suppression
// and a frame-aligned valid/ready value update.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [3:0]  an,
  output logic [7:0]  out,
  output logic        frame_done
);

  localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam state_t GAP_STATE = (BLANK_TICKS > 0) ? BLANK : SHOW;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boundary;
  logic [15:0]      disp_q, disp_d, shadow_q;
  logic             pending_q, accept;
  logic [3:0]       nib;
  logic [7:0]       dec;
  logic             lz_dark;
  logic [3:0]       an_d;
  logic [7:0]       seg_d;
  logic             fd_d;

  assign value_ready = !pending_q;
  assign accept      = value_valid && !pending_q;

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q + CNT_ONE;
    boundary = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      digit_d = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          boundary = 1'b1;
          state_d  = GAP_STATE;
          digit_d  = 2'd0;
          cnt_d    = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d  = GAP_STATE;
            digit_d  = digit_q + 2'd1;
            cnt_d    = '0;
            boundary = (digit_q == 2'd3);
          end
        end
        default: begin
          state_d = IDLE;
          digit_d = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are built from the next state so they flip on the same edge as the FSM
  always_comb begin
    disp_d = (boundary && pending_q) ? shadow_q : disp_q;
    unique case (digit_d)
      2'd0: begin nib = disp_d[3:0];   lz_dark = 1'b0;                             end
      2'd1: begin nib = disp_d[7:4];   lz_dark = blank_lz && (disp_d[15:4] == '0);  end
      2'd2: begin nib = disp_d[11:8];  lz_dark = blank_lz && (disp_d[15:8] == '0);  end
      default: begin nib = disp_d[15:12]; lz_dark = blank_lz && (disp_d[15:12] == '0); end
    endcase
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_d == SHOW && !lz_dark) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = dec;
    end
    fd_d = (state_d == SHOW) && (digit_d == 2'd3) && (cnt_d == SHOW_LAST);
  end

  hex_to_seg u_dec (
    .hex (nib),
    .seg (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      digit_q    <= 2'd0;
      cnt_q      <= '0;
      disp_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      an         <= AN_OFF;
      out        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      if (accept) shadow_q <= value;
      pending_q  <= accept || (pending_q && !boundary);
      an         <= an_d;
      out        <= seg_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: expected display runs and frame_done cycles are queued, monitors compare.
module tb_seg_scan_ctrl;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    int         len;
  } run_t;

  logic        clk = 1'b0;
  logic        rst, enable, blank_lz, vld, en_z, vz;
  logic [15:0] value, value_z;
  logic        rdy_a, fd_a, rdy_z, fd_z;
  logic [3:0]  an_a, an_z;
  logic [7:0]  out_a, out_z;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, base = 0;
  bit mon_on = 1'b0;
  run_t rq[$], rqz[$];
  int   fq[$], fqz[$];
  logic [11:0] prev_a = 12'hFFF, prev_z = 12'hFFF;
  int   len_a = 0, len_z = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_ctrl #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .blank_lz(blank_lz),
    .value(value), .value_valid(vld), .value_ready(rdy_a),
    .an(an_a), .out(out_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(0)) dut_z (
    .clk(clk), .rst(rst), .enable(en_z), .blank_lz(1'b0),
    .value(value_z), .value_valid(vz), .value_ready(rdy_z),
    .an(an_z), .out(out_z), .frame_done(fd_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cmp_run(input string name, input run_t e, input logic [11:0] act, input int len);
    n_chk++;
    if (act[11:8] === e.an && act[7:0] === e.seg && (e.len == 0 || len == e.len)) n_pass++;
    else $display("FAIL %s: got an=%b out=%h len=%0d expected an=%b out=%h len=%0d",
                  name, act[11:8], act[7:0], len, e.an, e.seg, e.len);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] s, input int l);
    run_t r;
    r.an = a; r.seg = s; r.len = l;
    rq.push_back(r);
  endtask

  task automatic pushz(input logic [3:0] a, input logic [7:0] s, input int l);
    run_t r;
    r.an = a; r.seg = s; r.len = l;
    rqz.push_back(r);
  endtask

  // One full frame with 2-cycle gaps, including the gap that opens the next frame
  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push(4'b1110, s0, 8); push(4'b1111, 8'hFF, 2);
    push(4'b1101, s1, 8); push(4'b1111, 8'hFF, 2);
    push(4'b1011, s2, 8); push(4'b1111, 8'hFF, 2);
    push(4'b0111, s3, 8); push(4'b1111, 8'hFF, 2);
  endtask

  task automatic at(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if ({an_a, out_a} === prev_a) len_a++;
      else begin
        if (len_a > 0) begin
          if (rq.size() == 0) begin
            n_chk++;
            $display("FAIL run_a: unexpected run an=%b out=%h len=%0d", prev_a[11:8], prev_a[7:0], len_a);
          end else cmp_run("run_a", rq.pop_front(), prev_a, len_a);
        end
        prev_a = {an_a, out_a};
        len_a  = 1;
      end
      if (fd_a === 1'b1) begin
        if (fq.size() == 0) begin
          n_chk++;
          $display("FAIL frame_done_a: unexpected pulse at cycle %0d", cyc - base);
        end else chk("frame_done_a", cyc - base, fq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if ({an_z, out_z} === prev_z) len_z++;
      else begin
        if (len_z > 0) begin
          if (rqz.size() == 0) begin
            n_chk++;
            $display("FAIL run_z: unexpected run an=%b out=%h len=%0d", prev_z[11:8], prev_z[7:0], len_z);
          end else cmp_run("run_z", rqz.pop_front(), prev_z, len_z);
        end
        prev_z = {an_z, out_z};
        len_z  = 1;
      end
      if (fd_z === 1'b1) begin
        if (fqz.size() == 0) begin
          n_chk++;
          $display("FAIL frame_done_z: unexpected pulse at cycle %0d", cyc - base);
        end else chk("frame_done_z", cyc - base, fqz.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b0; en_z = 1'b0; blank_lz = 1'b0;
    value = '0; vld = 1'b0; value_z = '0; vz = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_an", an_a, 4'b1111);
    chk("reset_out", out_a, 8'hFF);
    chk("reset_ready", rdy_a, 1'b1);
    chk("reset_frame_done", fd_a, 1'b0);
    chk("reset_an_z", an_z, 4'b1111);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // expected display runs, dut with 2-cycle blanking
    push(4'b1111, 8'hFF, 0);
    push_frame(8'h8E, 8'hB0, 8'h88, 8'hF9);          // 0x1A3F
    push_frame(8'h8E, 8'hB0, 8'h88, 8'hF9);          // 0x1A3F, update pending
    push_frame(8'hF9, 8'hC0, 8'hC0, 8'hC0);          // 0x0001
    push(4'b1110, 8'h92, 8); push(4'b1111, 8'hFF, 32);  // 0x0005 blank_lz
    push(4'b1110, 8'hC0, 8); push(4'b1111, 8'hFF, 2);   // 0x0100 blank_lz
    push(4'b1101, 8'hC0, 8); push(4'b1111, 8'hFF, 2);
    push(4'b1011, 8'hF9, 8); push(4'b1111, 8'hFF, 12);
    push(4'b1110, 8'hC0, 8); push(4'b1111, 8'hFF, 2);   // 0x0100, enable dropped in digit 2
    push(4'b1101, 8'hC0, 8); push(4'b1111, 8'hFF, 2);
    push(4'b1011, 8'hF9, 3); push(4'b1111, 8'hFF, 7);
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);          // 0x4321 after re-enable
    fq = '{39, 79, 119, 159, 199, 269};

    // back-to-back digits, no blanking
    pushz(4'b1111, 8'hFF, 0);
    for (int f = 0; f < 8; f++) begin
      pushz(4'b1110, 8'h8E, 8); pushz(4'b1101, 8'hB0, 8);
      pushz(4'b1011, 8'h88, 8); pushz(4'b0111, 8'hF9, 8);
      fqz.push_back(31 + 32 * f);
    end
    pushz(4'b1110, 8'h8E, 8); pushz(4'b1101, 8'hB0, 8);

    mon_on = 1'b1;
    value = 16'h1A3F; vld = 1'b1; value_z = 16'h1A3F; vz = 1'b1;
    @(negedge clk);
    vld = 1'b0; vz = 1'b0;
    chk("ready_low_after_accept", rdy_a, 1'b0);
    enable = 1'b1; en_z = 1'b1;
    @(negedge clk);
    base = cyc;

    at(53); vld = 1'b1; value = 16'h0001;
    at(54); value = 16'h2222;
    at(59); chk("ready_low_until_boundary", rdy_a, 1'b0); vld = 1'b0;
    at(80); chk("ready_high_after_boundary", rdy_a, 1'b1);
    at(89); vld = 1'b1; value = 16'h0005;
    at(90); vld = 1'b0;
    at(120); blank_lz = 1'b1;
    at(124); vld = 1'b1; value = 16'h0100;
    at(125); vld = 1'b0;
    at(200); blank_lz = 1'b0;
    at(204); vld = 1'b1; value = 16'h4321;
    at(205); vld = 1'b0;
    at(224); enable = 1'b0;
    at(225); chk("disable_an_dark", an_a, 4'b1111); chk("disable_out_dark", out_a, 8'hFF);
    at(227); chk("pending_kept_disabled", rdy_a, 1'b0);
    at(229); enable = 1'b1;
    at(274); vld = 1'b1; value = 16'hBEEF;
    at(275); vld = 1'b0; mon_on = 1'b0;
    chk("runs_a_drained", rq.size(), 0);
    chk("runs_z_drained", rqz.size(), 0);
    chk("fd_a_drained", fq.size(), 0);
    chk("fd_z_drained", fqz.size(), 0);
    at(276); chk("ready_low_before_rst", rdy_a, 1'b0);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midcycle_rst_an", an_a, 4'b1111);
    chk("midcycle_rst_out", out_a, 8'hFF);
    chk("midcycle_rst_ready", rdy_a, 1'b1);
    chk("midcycle_rst_frame_done", fd_a, 1'b0);
    chk("midcycle_rst_an_z", an_z, 4'b1111);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
